// File: rtl/axi_pkg.sv
// Shared definitions for the single-beat AXI-to-SRAM slave:
// FSM state encodings and AXI response codes.
package axi_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_RAM   = 3'd1;
  localparam logic [2:0] ST_RD_LATCH = 3'd2;
  localparam logic [2:0] ST_RD_RESP  = 3'd3;
  localparam logic [2:0] ST_WR_DATA  = 3'd4;
  localparam logic [2:0] ST_WR_RAM   = 3'd5;
  localparam logic [2:0] ST_WR_RESP  = 3'd6;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_sram_slave.sv
// Single-beat AXI slave in front of an external synchronous SRAM.
// One transaction in flight at a time; reads win over writes in IDLE.
// Bursts (len != 0) are answered with one SLVERR beat and never touch the SRAM.
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where both valid and ready are 1; the side asserting valid holds it and
// its payload stable until that edge.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // AR channel
  input  logic [3:0]        arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic              arvalid,
  output logic              arready,
  // R channel
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  // AW channel
  input  logic [3:0]        awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic              awvalid,
  output logic              awready,
  // W channel
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  // B channel
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  // SRAM port (read data arrives one cycle after ram_en)
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  logic [2:0]        state;
  logic [3:0]        id_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        len_r;
  logic [31:0]       wdata_r;
  logic [3:0]        wstrb_r;
  logic [31:0]       rdata_r;
  logic              burst_err;

  // Size, W id/last and the byte offset are irrelevant for word-wide single beats.
  logic unused_inputs;
  assign unused_inputs = ^{arsize, awsize, wid, wlast, addr_r[1:0]};

  assign burst_err = (len_r != 8'd0);

  // Transaction FSM: latch the request, sequence the SRAM access, hold the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      id_r    <= '0;
      addr_r  <= '0;
      len_r   <= '0;
      wdata_r <= '0;
      wstrb_r <= '0;
      rdata_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arvalid) begin
            id_r   <= arid;
            addr_r <= araddr;
            len_r  <= arlen;
            if (arlen != 8'd0) begin
              rdata_r <= '0;
              state   <= ST_RD_RESP;
            end else begin
              state   <= ST_RD_RAM;
            end
          end else if (awvalid) begin
            id_r   <= awid;
            addr_r <= awaddr;
            len_r  <= awlen;
            state  <= ST_WR_DATA;
          end
        end
        ST_RD_RAM:   state <= ST_RD_LATCH;
        ST_RD_LATCH: begin
          rdata_r <= ram_rdata;
          state   <= ST_RD_RESP;
        end
        ST_RD_RESP: if (rready) state <= ST_IDLE;
        ST_WR_DATA: begin
          if (wvalid) begin
            wdata_r <= wdata;
            wstrb_r <= wstrb;
            state   <= burst_err ? ST_WR_RESP : ST_WR_RAM;
          end
        end
        ST_WR_RAM:  state <= ST_WR_RESP;
        ST_WR_RESP: if (bready) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Channel and SRAM outputs decode straight from the state; ready is
  // gated by reset so every handshake output is low while reset is held.
  always_comb begin
    arready   = (state == ST_IDLE) && !reset;
    awready   = (state == ST_IDLE) && !reset && !arvalid;
    rvalid    = (state == ST_RD_RESP);
    rlast     = (state == ST_RD_RESP);
    rid       = id_r;
    rdata     = rdata_r;
    rresp     = burst_err ? RESP_SLVERR : RESP_OKAY;
    wready    = (state == ST_WR_DATA);
    bvalid    = (state == ST_WR_RESP);
    bid       = id_r;
    bresp     = burst_err ? RESP_SLVERR : RESP_OKAY;
    ram_en    = (state == ST_RD_RAM) || (state == ST_WR_RAM);
    ram_wen   = (state == ST_WR_RAM) ? wstrb_r : 4'h0;
    ram_addr  = {addr_r[ADDR_W-1:2], 2'b00};
    ram_wdata = wdata_r;
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural byte-writable SRAM.
module tb_axi_sram_slave;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        arid = '0;
  logic [ADDR_W-1:0] araddr = '0;
  logic [7:0]        arlen = '0;
  logic [2:0]        arsize = 3'd2;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [3:0]        rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [3:0]        awid = '0;
  logic [ADDR_W-1:0] awaddr = '0;
  logic [7:0]        awlen = '0;
  logic [2:0]        awsize = 3'd2;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [3:0]        wid = '0;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wlast = 1'b1;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [3:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic              ram_en;
  logic [3:0]        ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = '0;

  int checks = 0;
  int failures = 0;
  int en_cnt = 0;
  int wen_cnt = 0;

  logic [31:0] mem [0:1023];

  axi_sram_slave #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Clock
  always #5 clk = ~clk;

  // SRAM model: byte-enabled write, registered read (old data on a write cycle)
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) mem[ram_addr[11:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      ram_rdata <= mem[ram_addr[11:2]];
    end
  end

  // SRAM activity monitor
  always @(negedge clk) begin
    if (ram_en) en_cnt++;
    if (ram_wen != 4'h0) wen_cnt++;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rvalid(output bit ok);
    int n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    ok = rvalid;
  endtask

  task automatic wait_bvalid(output bit ok);
    int n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    ok = bvalid;
  endtask

  // Full single-beat read with bounded waits; ok=0 if any wait expired
  task automatic run_read(input logic [31:0] addr, input logic [3:0] id,
                          output logic [31:0] data, output logic [1:0] resp,
                          output logic [3:0] id_o, output bit ok);
    int n = 0;
    araddr = addr; arid = id; arlen = 8'd0; arvalid = 1'b1;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    wait_rvalid(ok);
    data = rdata; resp = rresp; id_o = rid;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  // Full write (AW, W, B) with bounded waits
  task automatic run_write(input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] len, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic [3:0] id_o, output bit ok);
    int n = 0;
    awaddr = addr; awid = id; awlen = len; awvalid = 1'b1;
    while (!awready && n < 20) begin tick(); n++; end
    tick();
    awvalid = 1'b0;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    n = 0;
    while (!wready && n < 20) begin tick(); n++; end
    tick();
    wvalid = 1'b0;
    wait_bvalid(ok);
    resp = bresp; id_o = bid;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (arready !== 1'b0) begin failures++; $display("FAIL rst_arready: got %b expected 0", arready); end
    checks++; if (awready !== 1'b0) begin failures++; $display("FAIL rst_awready: got %b expected 0", awready); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid: got %b expected 0", rvalid); end
    checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL rst_bvalid: got %b expected 0", bvalid); end
    checks++; if (wready !== 1'b0) begin failures++; $display("FAIL rst_wready: got %b expected 0", wready); end
    checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL rst_ram_en: got %b expected 0", ram_en); end
    reset = 1'b0;
    #1;
    checks++; if (arready !== 1'b1) begin failures++; $display("FAIL idle_arready: got %b expected 1", arready); end
    checks++; if (awready !== 1'b1) begin failures++; $display("FAIL idle_awready: got %b expected 1", awready); end
    tick();
  endtask

  task automatic test_single_read();
    mem[10'h040] = 32'hDEADBEEF;
    arid = 4'd1; araddr = 32'h102; arlen = 8'd0; arvalid = 1'b1;
    tick();                 // handshake cycle T ends here; now in T+1
    arvalid = 1'b0;
    checks++; if (ram_en !== 1'b1) begin failures++; $display("FAIL rd_ram_en_t1: got %b expected 1", ram_en); end
    checks++; if (ram_addr !== 32'h100) begin failures++; $display("FAIL rd_ram_addr: got %h expected 00000100", ram_addr); end
    checks++; if (ram_wen !== 4'h0) begin failures++; $display("FAIL rd_ram_wen: got %h expected 0", ram_wen); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rd_rvalid_t1: got %b expected 0", rvalid); end
    tick();                 // T+2
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rd_rvalid_t2: got %b expected 0", rvalid); end
    checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL rd_ram_en_t2: got %b expected 0", ram_en); end
    tick();                 // T+3
    checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL rd_rvalid_t3: got %b expected 1", rvalid); end
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_rdata: got %h expected deadbeef", rdata); end
    checks++; if (rid !== 4'd1) begin failures++; $display("FAIL rd_rid: got %h expected 1", rid); end
    checks++; if (rresp !== 2'b00) begin failures++; $display("FAIL rd_rresp: got %b expected 00", rresp); end
    checks++; if (rlast !== 1'b1) begin failures++; $display("FAIL rd_rlast: got %b expected 1", rlast); end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rd_rvalid_done: got %b expected 0", rvalid); end
    checks++; if (arready !== 1'b1) begin failures++; $display("FAIL rd_arready_next: got %b expected 1", arready); end
  endtask

  task automatic test_byte_write();
    logic [31:0] d; logic [1:0] rs; logic [3:0] ido; bit ok;
    mem[10'h080] = 32'h12345600;
    awid = 4'd1; awaddr = 32'h200; awlen = 8'd0; awvalid = 1'b1;
    #1;
    checks++; if (awready !== 1'b1) begin failures++; $display("FAIL wr_awready: got %b expected 1", awready); end
    checks++; if (wready !== 1'b0) begin failures++; $display("FAIL wr_wready_aw: got %b expected 0", wready); end
    tick();
    awvalid = 1'b0;
    checks++; if (wready !== 1'b1) begin failures++; $display("FAIL wr_wready: got %b expected 1", wready); end
    wdata = 32'h000000AB; wstrb = 4'h1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    checks++; if (ram_en !== 1'b1) begin failures++; $display("FAIL wr_ram_en: got %b expected 1", ram_en); end
    checks++; if (ram_wen !== 4'h1) begin failures++; $display("FAIL wr_ram_wen: got %h expected 1", ram_wen); end
    checks++; if (ram_addr !== 32'h200) begin failures++; $display("FAIL wr_ram_addr: got %h expected 00000200", ram_addr); end
    checks++; if (ram_wdata !== 32'h000000AB) begin failures++; $display("FAIL wr_ram_wdata: got %h expected 000000ab", ram_wdata); end
    tick();
    checks++; if (ram_wen !== 4'h0) begin failures++; $display("FAIL wr_ram_wen_off: got %h expected 0", ram_wen); end
    checks++; if (bvalid !== 1'b1) begin failures++; $display("FAIL wr_bvalid: got %b expected 1", bvalid); end
    checks++; if (bid !== 4'd1) begin failures++; $display("FAIL wr_bid: got %h expected 1", bid); end
    checks++; if (bresp !== 2'b00) begin failures++; $display("FAIL wr_bresp: got %b expected 00", bresp); end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL wr_bvalid_done: got %b expected 0", bvalid); end
    run_read(32'h200, 4'd2, d, rs, ido, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wr_rb_timeout: got %b expected 1", ok); end
    checks++; if (d !== 32'h123456AB) begin failures++; $display("FAIL wr_rb_data: got %h expected 123456ab", d); end
  endtask

  task automatic test_simultaneous();
    bit ok; logic [1:0] rs; logic [3:0] ido;
    arid = 4'd3; araddr = 32'h100; arlen = 8'd0; arvalid = 1'b1;
    awid = 4'd2; awaddr = 32'h300; awlen = 8'd0; awvalid = 1'b1;
    #1;
    checks++; if (arready !== 1'b1) begin failures++; $display("FAIL sim_arready: got %b expected 1", arready); end
    checks++; if (awready !== 1'b0) begin failures++; $display("FAIL sim_awready: got %b expected 0", awready); end
    tick();
    arvalid = 1'b0;
    checks++; if (wready !== 1'b0) begin failures++; $display("FAIL sim_no_wready: got %b expected 0", wready); end
    wait_rvalid(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL sim_r_timeout: got %b expected 1", ok); end
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sim_rdata: got %h expected deadbeef", rdata); end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checks++; if (awready !== 1'b1) begin failures++; $display("FAIL sim_awready_after: got %b expected 1", awready); end
    tick();
    awvalid = 1'b0;
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    wait_bvalid(ok);
    rs = bresp; ido = bid;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL sim_b_timeout: got %b expected 1", ok); end
    checks++; if (ido !== 4'd2) begin failures++; $display("FAIL sim_bid: got %h expected 2", ido); end
    checks++; if (rs !== 2'b00) begin failures++; $display("FAIL sim_bresp: got %b expected 00", rs); end
    checks++; if (mem[10'h0C0] !== 32'hCAFEF00D) begin failures++; $display("FAIL sim_mem: got %h expected cafef00d", mem[10'h0C0]); end
  endtask

  task automatic test_backpressure();
    bit ok;
    arid = 4'd4; araddr = 32'h100; arlen = 8'd0; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    wait_rvalid(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_r_timeout: got %b expected 1", ok); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL bp_rvalid[%0d]: got %b expected 1", i, rvalid); end
      checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL bp_rdata[%0d]: got %h expected deadbeef", i, rdata); end
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    awid = 4'd7; awaddr = 32'h204; awlen = 8'd0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    wait_bvalid(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_b_timeout: got %b expected 1", ok); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bvalid !== 1'b1) begin failures++; $display("FAIL bp_bvalid[%0d]: got %b expected 1", i, bvalid); end
      checks++; if (bid !== 4'd7) begin failures++; $display("FAIL bp_bid[%0d]: got %h expected 7", i, bid); end
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL bp_bvalid_done: got %b expected 0", bvalid); end
  endtask

  task automatic test_burst_error();
    int en0; int wen0; bit ok; logic [1:0] rs; logic [3:0] ido;
    en0 = en_cnt;
    arid = 4'd5; araddr = 32'h100; arlen = 8'd3; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL be_rvalid: got %b expected 1", rvalid); end
    checks++; if (rresp !== 2'b10) begin failures++; $display("FAIL be_rresp: got %b expected 10", rresp); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL be_rdata: got %h expected 0", rdata); end
    checks++; if (rlast !== 1'b1) begin failures++; $display("FAIL be_rlast: got %b expected 1", rlast); end
    checks++; if (rid !== 4'd5) begin failures++; $display("FAIL be_rid: got %h expected 5", rid); end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checks++; if (en_cnt !== en0) begin failures++; $display("FAIL be_rd_ram_en: got %0d accesses expected 0", en_cnt - en0); end
    wen0 = wen_cnt;
    run_write(32'h300, 4'd6, 8'd1, 32'hFFFFFFFF, 4'hF, rs, ido, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL be_b_timeout: got %b expected 1", ok); end
    checks++; if (rs !== 2'b10) begin failures++; $display("FAIL be_bresp: got %b expected 10", rs); end
    checks++; if (ido !== 4'd6) begin failures++; $display("FAIL be_bid: got %h expected 6", ido); end
    checks++; if (wen_cnt !== wen0) begin failures++; $display("FAIL be_ram_wen: got %0d write cycles expected 0", wen_cnt - wen0); end
    checks++; if (mem[10'h0C0] !== 32'hCAFEF00D) begin failures++; $display("FAIL be_mem: got %h expected cafef00d", mem[10'h0C0]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] rs; logic [3:0] ido; bit ok; int en0;
    awid = 4'd9; awaddr = 32'h100; awlen = 8'd0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checks++; if (wready !== 1'b1) begin failures++; $display("FAIL rm_wready_pre: got %b expected 1", wready); end
    en0 = en_cnt;
    reset = 1'b1;
    #1;
    checks++; if (wready !== 1'b0) begin failures++; $display("FAIL rm_wready: got %b expected 0", wready); end
    checks++; if (arready !== 1'b0) begin failures++; $display("FAIL rm_arready: got %b expected 0", arready); end
    checks++; if (awready !== 1'b0) begin failures++; $display("FAIL rm_awready: got %b expected 0", awready); end
    checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL rm_bvalid: got %b expected 0", bvalid); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rm_rvalid: got %b expected 0", rvalid); end
    checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL rm_ram_en: got %b expected 0", ram_en); end
    checks++; if (ram_wen !== 4'h0) begin failures++; $display("FAIL rm_ram_wen: got %h expected 0", ram_wen); end
    tick();
    tick();
    reset = 1'b0;
    wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick();
    checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL rm_no_b: got %b expected 0", bvalid); end
    checks++; if (en_cnt !== en0) begin failures++; $display("FAIL rm_no_ram: got %0d accesses expected 0", en_cnt - en0); end
    run_read(32'h100, 4'd8, d, rs, ido, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rm_rd_timeout: got %b expected 1", ok); end
    checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL rm_rd_data: got %h expected deadbeef", d); end
    checks++; if (ido !== 4'd8) begin failures++; $display("FAIL rm_rd_id: got %h expected 8", ido); end
    checks++; if (rs !== 2'b00) begin failures++; $display("FAIL rm_rd_resp: got %b expected 00", rs); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] rs; logic [3:0] ido; bit ok;
    run_write(32'h208, 4'hA, 8'd0, 32'h0BADF00D, 4'hF, rs, ido, ok);
    checks++; if (arready !== 1'b1) begin failures++; $display("FAIL b2b_arready: got %b expected 1", arready); end
    run_read(32'h208, 4'hB, d, rs, ido, ok);
    checks++; if (d !== 32'h0BADF00D) begin failures++; $display("FAIL b2b_data: got %h expected 0badf00d", d); end
    checks++; if (awready !== 1'b1) begin failures++; $display("FAIL b2b_awready: got %b expected 1", awready); end
    run_read(32'h204, 4'hC, d, rs, ido, ok);
    checks++; if (d !== 32'h55AA55AA) begin failures++; $display("FAIL b2b_data2: got %h expected 55aa55aa", d); end
    checks++; if (ido !== 4'hC) begin failures++; $display("FAIL b2b_id2: got %h expected c", ido); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_single_read();
    test_byte_write();
    test_simultaneous();
    test_backpressure();
    test_burst_error();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
